// File: rtl/vga_scan_engine.sv
// vga_scan_engine: VGA timing, downscaled framebuffer addressing and DAC drive.
// Ports: vga_clk, rst_n (async, active-low), pll_lock.
//   rd_addr/rd_en/rd_data form the framebuffer read port.
//   pattern_sel requests a test pattern. frame_start pulses at (0,0).
//   VGA_R/G/B, VGA_HS/VS, VGA_BLANK_N, VGA_SYNC_N, VGA_CLK drive the connector.
// Optional checkerboard test pattern: define VGA_TEST_PATTERN_EN.
module vga_scan_engine #(
    parameter int H_VISIBLE   = 640,
    parameter int H_FRONT     = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BACK      = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FRONT     = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BACK      = 33,
    parameter bit HS_POL      = 1'b0,
    parameter bit VS_POL      = 1'b0,
    parameter int SCALE_SHIFT = 2,
    parameter int PIX_W       = 8,
    parameter int RD_LATENCY  = 2,
    parameter int ADDR_W      = 15
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    input  logic              pll_lock,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_en,
    input  logic [PIX_W-1:0]  rd_data,
    input  logic              pattern_sel,
    output logic              frame_start,
    output logic [7:0]        VGA_R,
    output logic [7:0]        VGA_G,
    output logic [7:0]        VGA_B,
    output logic              VGA_HS,
    output logic              VGA_VS,
    output logic              VGA_BLANK_N,
    output logic              VGA_SYNC_N,
    output logic              VGA_CLK
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int FB_W    = H_VISIBLE >> SCALE_SHIFT;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] H_SUB  = HW'((1 << SCALE_SHIFT) - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END = VW'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [VW-1:0] V_SUB  = VW'((1 << SCALE_SHIFT) - 1);

    logic              count_en;
    logic [HW-1:0]     p;
    logic [VW-1:0]     l;
    logic [HW-1:0]     col;
    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] addr_q;
    logic              vis;
    logic              hs_act;
    logic              vs_act;
    logic              pat_now;
    logic              chk_now;

    // Stage bits: {visible, hs, vs, pattern, checker}
    logic [4:0]        st_in;
    logic [4:0]        st_out;
    logic [4:0]        st_d [RD_LATENCY];
    logic [7:0]        src_r;
    logic [7:0]        src_g;
    logic [7:0]        src_b;

    assign vis    = count_en && (p < H_VIS) && (l < V_VIS);
    assign hs_act = (p >= HS_BEG) && (p < HS_END);
    assign vs_act = (l >= VS_BEG) && (l < VS_END);

    assign frame_start = count_en && (p == '0) && (l == '0);
    assign rd_en       = vis && !pat_now;
    // Hold the last issued address while no read is in flight.
    assign rd_addr     = rd_en ? (row_base + ADDR_W'(col)) : addr_q;

    assign VGA_SYNC_N = 1'b0;
    assign VGA_CLK    = vga_clk;

`ifdef VGA_TEST_PATTERN_EN
    logic        pat_q;
    logic [31:0] cx;
    logic [31:0] ly;

    // The frame_start cycle already belongs to the new frame.
    assign pat_now = frame_start ? pattern_sel : pat_q;
    assign cx      = 32'(col);
    assign ly      = 32'(l) >> SCALE_SHIFT;
    assign chk_now = ((cx ^ ly) & 32'd8) != 32'd0;

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= 1'b0;
        end else if (frame_start) begin
            pat_q <= pattern_sel;
        end
    end
`else
    logic unused_pattern_sel;

    assign unused_pattern_sel = pattern_sel;
    assign pat_now            = 1'b0;
    assign chk_now            = 1'b0;
`endif

    // Enable latches on the first locked edge and ignores later drops.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            count_en <= 1'b0;
        end else if (pll_lock) begin
            count_en <= 1'b1;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            p        <= '0;
            l        <= '0;
            col      <= '0;
            row_base <= '0;
        end else if (count_en) begin
            if (p == H_LAST) begin
                p   <= '0;
                col <= '0;
                if (l == V_LAST) begin
                    l        <= '0;
                    row_base <= '0;
                end else begin
                    l <= l + 1'b1;
                    // Last line of a framebuffer row moves to the next row.
                    if ((l < V_VIS) && ((l & V_SUB) == V_SUB)) begin
                        row_base <= row_base + ADDR_W'(FB_W);
                    end
                end
            end else begin
                p <= p + 1'b1;
                if ((p < H_VIS) && ((p & H_SUB) == H_SUB)) begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
        end else if (rd_en) begin
            addr_q <= rd_addr;
        end
    end

    // Delay flags to line up with read data returning from the RAM.
    assign st_in  = {vis, hs_act, vs_act, pat_now, chk_now};
    assign st_out = st_d[RD_LATENCY-1];

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RD_LATENCY; i++) begin
                st_d[i] <= '0;
            end
        end else begin
            st_d[0] <= st_in;
            for (int i = 1; i < RD_LATENCY; i++) begin
                st_d[i] <= st_d[i-1];
            end
        end
    end

    generate
        if (PIX_W == 24) begin : g_rgb
            assign src_r = rd_data[23:16];
            assign src_g = rd_data[15:8];
            assign src_b = rd_data[7:0];
        end else begin : g_mono
            assign src_r = rd_data[7:0];
            assign src_g = rd_data[7:0];
            assign src_b = rd_data[7:0];
        end
    endgenerate

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= ~HS_POL;
            VGA_VS      <= ~VS_POL;
            VGA_BLANK_N <= 1'b0;
        end else begin
            VGA_HS      <= st_out[3] ? HS_POL : ~HS_POL;
            VGA_VS      <= st_out[2] ? VS_POL : ~VS_POL;
            VGA_BLANK_N <= st_out[4];
            if (!st_out[4]) begin
                VGA_R <= '0;
                VGA_G <= '0;
                VGA_B <= '0;
            end else if (st_out[1]) begin
                VGA_R <= {8{st_out[0]}};
                VGA_G <= {8{st_out[0]}};
                VGA_B <= {8{st_out[0]}};
            end else begin
                VGA_R <= src_r;
                VGA_G <= src_g;
                VGA_B <= src_b;
            end
        end
    end

endmodule
